iob_reg_pipe: RTL and testbench

Parametrised multi-stage pipeline register with valid/ready handshake on both sides. It is the stallable successor of the single enable/reset register. It gives DEPTH register stages with per-stage valid bits, clock-enable gating, synchronous clear and an occupancy count. It sits on datapaths that need timing slack without losing or duplicating words under backpressure, such as between the Ethernet DMA and buffer logic.

---
 rtl/iob_reg_pipe.sv | 102 ++++++++++
 tb/tb_iob_reg_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_reg_pipe.sv
// rtl/iob_reg_pipe.sv - DEPTH-stage stallable pipeline register with valid/ready handshake.
// Define IOB_REG_PIPE_SKID_EN to add a one-entry skid register that cuts the m_ready_i to s_ready_o path.
module iob_reg_pipe #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                DEPTH   = 2
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         cke_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [DATA_W-1:0]            s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic [$clog2(DEPTH+2)-1:0]   level_o
);

  localparam int LVL_W = $clog2(DEPTH+2);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              up_xfer;
  logic              dn_xfer;

  // Readiness ripples from the output back to stage 0; any bubble makes everything behind it ready.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = m_ready_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      chain  = cke_i & (~valid_q[k] | chain);
      adv[k] = chain;
    end
  end

  assign m_valid_o = cke_i & valid_q[DEPTH-1];
  assign m_data_o  = data_q[DEPTH-1];
  assign up_xfer   = s_valid_i & s_ready_o;
  assign dn_xfer   = m_valid_o & m_ready_i;

`ifdef IOB_REG_PIPE_SKID_EN
  logic              skid_valid_q;
  logic [DATA_W-1:0] skid_data_q;

  assign s_ready_o = cke_i & ~skid_valid_q;
  // A held skid word always goes ahead of new input; no input is accepted while it is held.
  assign src_valid = skid_valid_q | up_xfer;
  assign src_data  = skid_valid_q ? skid_data_q : s_data_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= RST_VAL;
    end else if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= RST_VAL;
    end else if (skid_valid_q && adv[0]) begin
      skid_valid_q <= 1'b0;
    end else if (up_xfer && !adv[0]) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= s_data_i;
    end
  end
`else
  assign s_ready_o = adv[0];
  assign src_valid = up_xfer;
  assign src_data  = s_data_i;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= '0;
      level_o <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
    end else if (rst_i) begin
      valid_q <= '0;
      level_o <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
    end else begin
      // Data only moves with a valid source, so draining words leave stale data in place.
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
      if (adv[0]) begin
        valid_q[0] <= src_valid;
        if (src_valid) data_q[0] <= src_data;
      end
      if (up_xfer && !dn_xfer)      level_o <= level_o + LVL_W'(1);
      else if (dn_xfer && !up_xfer) level_o <= level_o - LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_iob_reg_pipe.sv
// tb/tb_iob_reg_pipe.sv - Scoreboard testbench for iob_reg_pipe (DEPTH=3, RST_VAL=0xA5).
module tb_iob_reg_pipe;

  localparam int          DATA_W  = 16;
  localparam int          DEPTH   = 3;
  localparam logic [15:0] RST_VAL = 16'h00A5;
  localparam int          LVL_W   = $clog2(DEPTH+2);
`ifdef IOB_REG_PIPE_SKID_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b1;
  logic              cke_i = 1'b1;
  logic              rst_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic [DATA_W-1:0] m_data_o;
  logic [LVL_W-1:0]  level_o;

  int                n_cmp = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_w;
  int                model_level = 0;
  logic [DATA_W-1:0] next_word = 16'd1;

  iob_reg_pipe #(.DATA_W(DATA_W), .RST_VAL(RST_VAL), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: push accepted words, pop and compare on every output transfer, track occupancy.
  always @(negedge clk_i) begin
    if (arst_i) begin
      sb.delete();
      model_level = 0;
    end else begin
      n_cmp++;
      if (int'(level_o) !== model_level) begin
        n_fail++;
        $display("FAIL level_o: got %0d want %0d", level_o, model_level);
      end
      if (rst_i) begin
        sb.delete();
        model_level = 0;
      end else begin
        if (m_valid_o && m_ready_i) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %0h want none", m_data_o);
          end else begin
            exp_w = sb.pop_front();
            if (m_data_o !== exp_w) begin
              n_fail++;
              $display("FAIL m_data_o: got %0h want %0h", m_data_o, exp_w);
            end
          end
          model_level--;
        end
        if (s_valid_i && s_ready_o) begin
          sb.push_back(s_data_i);
          model_level++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int k;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    cke_i     = 1'b1;
    for (k = 0; k < 50 && level_o != 0; k++) tick();
    tick();
    n_cmp++;
    if (level_o != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got level %0d pending %0d want 0 0", level_o, sb.size());
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    arst_i = 1'b0;
    tick();
    s_valid_i = 1'b1; m_ready_i = 1'b1; s_data_i = next_word;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    arst_i = 1'b1;
    #1;
    n_cmp++;
    if (m_valid_o !== 1'b0 || m_data_o !== RST_VAL || level_o !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b d=%0h l=%0d want v=0 d=a5 l=0", m_valid_o, m_data_o, level_o);
    end
    s_valid_i = 1'b0;
    tick();
    arst_i = 1'b0;
    #1;
    n_cmp++;
    if (s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", s_ready_o);
    end
    drain();
  endtask

  task automatic test_streaming();
    int lat = -1;
    int outs = 0;
    s_valid_i = 1'b1; m_ready_i = 1'b1; s_data_i = next_word;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (m_valid_o && lat < 0) lat = c;
      if (m_valid_o && m_ready_i) outs++;
      if (c == 15) begin
        n_cmp++;
        if (level_o != LVL_W'(DEPTH)) begin
          n_fail++;
          $display("FAIL stream_level: got %0d want %0d", level_o, DEPTH);
        end
      end
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    n_cmp++;
    if (lat != DEPTH || outs != 20 - DEPTH) begin
      n_fail++;
      $display("FAIL stream_timing: got lat=%0d outs=%0d want lat=%0d outs=%0d", lat, outs, DEPTH, 20 - DEPTH);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    s_valid_i = 1'b1; m_ready_i = 1'b0; s_data_i = next_word;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) begin acc++; next_word++; end
      tick();
      s_data_i = next_word;
    end
    @(negedge clk_i);
    n_cmp++;
    if (acc != CAP || s_ready_o !== 1'b0 || level_o != LVL_W'(CAP)) begin
      n_fail++;
      $display("FAIL backpressure_full: got acc=%0d rdy=%b lvl=%0d want acc=%0d rdy=0 lvl=%0d", acc, s_ready_o, level_o, CAP, CAP);
    end
    tick();
    m_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    drain();
  endtask

  task automatic test_cke();
    s_valid_i = 1'b1; m_ready_i = 1'b1; s_data_i = next_word;
    for (int c = 0; c < 60; c++) begin
      cke_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (!cke_i) begin
        n_cmp++;
        if (m_valid_o !== 1'b0 || s_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL cke_gating: got v=%b r=%b want 0 0", m_valid_o, s_ready_o);
        end
      end
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    drain();
  endtask

  task automatic test_sync_clear();
    int lat = -1;
    s_valid_i = 1'b1; m_ready_i = 1'b0; s_data_i = next_word;
    for (int c = 0; c < CAP + 3; c++) begin
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    rst_i = 1'b1; cke_i = 1'b0; s_valid_i = 1'b0;
    tick();
    rst_i = 1'b0; cke_i = 1'b1;
    @(negedge clk_i);
    n_cmp++;
    if (level_o !== '0 || m_valid_o !== 1'b0 || m_data_o !== RST_VAL) begin
      n_fail++;
      $display("FAIL sync_clear: got l=%0d v=%b d=%0h want 0 0 a5", level_o, m_valid_o, m_data_o);
    end
    tick();
    m_ready_i = 1'b1; s_valid_i = 1'b1; s_data_i = next_word;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      if (c == 0 && s_ready_o) next_word++;
      if (m_valid_o && lat < 0) lat = c;
      tick();
      s_valid_i = 1'b0;
      s_data_i  = next_word;
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_fail++;
      $display("FAIL clear_latency: got %0d want %0d", lat, DEPTH);
    end
    drain();
  endtask

  task automatic test_toggle();
    logic exp_rdy;
    s_valid_i = 1'b1; m_ready_i = 1'b0; s_data_i = next_word;
    for (int c = 0; c < 40; c++) begin
      m_ready_i = ~m_ready_i;
      @(negedge clk_i);
`ifdef IOB_REG_PIPE_SKID_EN
      exp_rdy = (level_o != LVL_W'(CAP));
`else
      exp_rdy = (level_o < LVL_W'(DEPTH)) | m_ready_i;
`endif
      n_cmp++;
      if (s_ready_o !== exp_rdy) begin
        n_fail++;
        $display("FAIL toggle_ready: got %b want %b (level %0d)", s_ready_o, exp_rdy, level_o);
      end
      if (s_valid_i && s_ready_o) next_word++;
      tick();
      s_data_i = next_word;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_cke();
    test_sync_clear();
    test_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
